// File: rtl/adc_sample_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : adc_sample_sequencer_if
// Brief    : Valid/ready write channel from the ADC sequencer into the data
//            RAM's ADC write port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface adc_sample_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/adc_sample_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : adc_sample_sequencer
// Brief    : Round-robin ADC sampler writing per-channel ring buffers into RAM.
//            Optional macro SEQ_TIMESTAMP_EN puts a 16-bit capture sequence
//            number in wr_data[31:16].
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module adc_sample_sequencer #(
    parameter int                       NUM_CH     = 2,
    parameter int                       DATA_W     = 16,
    parameter int                       DEPTH      = 640,
    parameter int                       ADDR_W     = 12,
    parameter logic [NUM_CH*ADDR_W-1:0] BASE_ADDRS = {12'hA80, 12'h800},
    parameter int                       INTERVAL   = 175000,
    localparam int                      CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int                      IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic                      clock,
    input  wire logic                      reset,
    input  wire logic                      enable,
    input  wire logic [NUM_CH*DATA_W-1:0]  ch_data,
    adc_sample_sequencer_if.master         wr,
    output logic      [CH_W-1:0]           cur_ch,
    output logic      [NUM_CH*IDX_W-1:0]   head_idx,
    output logic      [NUM_CH-1:0]         wrapped,
    output logic      [15:0]               overrun_cnt
);

    localparam int               c_CNT_W    = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(INTERVAL - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]  c_CH_LAST  = CH_W'(NUM_CH - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_REQ  = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_CNT_W-1:0]  r_count;
    logic [CH_W-1:0]     r_cur_ch;
    logic [CH_W-1:0]     r_req_ch;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic [15:0]         r_overrun;
    logic [NUM_CH-1:0]   r_wrapped;
    logic [IDX_W-1:0]    r_head      [NUM_CH];
    logic [IDX_W-1:0]    w_head_next [NUM_CH];
    logic [NUM_CH-1:0]   w_wrap_evt;

    logic                w_tick;
    logic                w_accept;
    logic                w_capture;
    logic                w_drop;
    logic [DATA_W-1:0]   w_sel_data;
    logic [ADDR_W-1:0]   w_sel_base;
    logic [IDX_W-1:0]    w_sel_head;
    logic [31:0]         w_wr_word;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        w_state_next = r_state;
        w_tick       = enable && (r_count == c_CNT_LAST);
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_tick) begin
                    w_capture    = 1'b1;
                    w_state_next = c_S_REQ;
                end
            end
            c_S_REQ: begin
                if (wr.wr_ready) begin
                    w_accept     = 1'b1;
                    w_capture    = w_tick;
                    w_state_next = w_tick ? c_S_REQ : c_S_IDLE;
                end else begin
                    w_drop = w_tick;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // Head advance for the channel whose write is being accepted
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_head_next[i] = r_head[i];
            w_wrap_evt[i]  = 1'b0;
            if (w_accept && (r_req_ch == CH_W'(i))) begin
                if (r_head[i] == c_IDX_LAST) begin
                    w_head_next[i] = '0;
                    w_wrap_evt[i]  = 1'b1;
                end else begin
                    w_head_next[i] = r_head[i] + 1'b1;
                end
            end
        end
    end

    // Post-acceptance head is used so a single-channel build never reuses a slot
    assign w_sel_data = ch_data[int'(r_cur_ch)*DATA_W +: DATA_W];
    assign w_sel_base = BASE_ADDRS[int'(r_cur_ch)*ADDR_W +: ADDR_W];
    assign w_sel_head = w_head_next[r_cur_ch];

`ifdef SEQ_TIMESTAMP_EN
    logic [15:0] r_seq;

    // Every tick consumes a number, including dropped ones, so gaps are visible
    always_ff @(posedge clock) begin
        if (reset) begin
            r_seq <= '0;
        end else if (w_tick) begin
            r_seq <= r_seq + 16'd1;
        end
    end

    assign w_wr_word = {r_seq, 16'(w_sel_data)};
`else
    assign w_wr_word = 32'(w_sel_data);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_cur_ch  <= '0;
            r_req_ch  <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_overrun <= '0;
            r_wrapped <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_head[i] <= '0;
            end
        end else begin
            if (!enable || (r_count == c_CNT_LAST)) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end

            if (w_tick) begin
                r_cur_ch <= (r_cur_ch == c_CH_LAST) ? '0 : r_cur_ch + 1'b1;
            end

            if (w_capture) begin
                r_req_ch <= r_cur_ch;
                r_addr   <= w_sel_base + ADDR_W'(w_sel_head);
                r_data   <= w_wr_word;
            end

            if (w_drop && (r_overrun != 16'hFFFF)) begin
                r_overrun <= r_overrun + 16'd1;
            end

            r_wrapped <= r_wrapped | w_wrap_evt;
            for (int i = 0; i < NUM_CH; i++) begin
                r_head[i] <= w_head_next[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign head_idx[g*IDX_W +: IDX_W] = r_head[g];
    end

    assign wr.wr_en     = (r_state == c_S_REQ);
    assign wr.wr_addr   = r_addr;
    assign wr.wr_data   = r_data;
    assign cur_ch       = r_cur_ch;
    assign wrapped      = r_wrapped;
    assign overrun_cnt  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_adc_sample_sequencer
// Brief    : Scoreboard bench for adc_sample_sequencer (2 ch, depth 4, interval 4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_adc_sample_sequencer;

    localparam int          NUM_CH   = 2;
    localparam int          DATA_W   = 16;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 12;
    localparam int          INTERVAL = 4;
    localparam logic [23:0] c_BASE   = {12'hA80, 12'h800};

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] ch_data;
    logic        cur_ch;
    logic [3:0]  head_idx;
    logic [1:0]  wrapped;
    logic [15:0] overrun_cnt;

    adc_sample_sequencer_if #(.ADDR_W(ADDR_W)) wr_bus ();

    adc_sample_sequencer #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .BASE_ADDRS (c_BASE),
        .INTERVAL   (INTERVAL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .ch_data     (ch_data),
        .wr          (wr_bus),
        .cur_ch      (cur_ch),
        .head_idx    (head_idx),
        .wrapped     (wrapped),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clock = ~clock;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q [$];
    exp_t log_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of the sampling rules
    bit          m_valid = 0;
    int          m_count, m_cur, m_pend_ch;
    bit          m_pending;
    int          m_head [NUM_CH];
    logic [1:0]  m_wrapped;
    logic [15:0] m_over;
    logic [15:0] m_seq;

    always @(posedge clock) begin
        bit   tick;
        exp_t e;
        if (reset) begin
            m_valid   = 1;
            m_count   = 0;
            m_cur     = 0;
            m_pending = 0;
            m_pend_ch = 0;
            m_wrapped = '0;
            m_over    = '0;
            m_seq     = '0;
            for (int i = 0; i < NUM_CH; i++) m_head[i] = 0;
            exp_q.delete();
        end else if (m_valid) begin
            tick = enable && (m_count == INTERVAL - 1);
            if (m_pending && wr_bus.wr_ready) begin
                m_head[m_pend_ch] = (m_head[m_pend_ch] + 1) % DEPTH;
                if (m_head[m_pend_ch] == 0) m_wrapped[m_pend_ch] = 1'b1;
                m_pending = 0;
            end
            if (tick) begin
                if (!m_pending) begin
                    e.addr = c_BASE[m_cur*12 +: 12] + 12'(m_head[m_cur]);
`ifdef SEQ_TIMESTAMP_EN
                    e.data = {m_seq, ch_data[m_cur*16 +: 16]};
`else
                    e.data = {16'h0, ch_data[m_cur*16 +: 16]};
`endif
                    exp_q.push_back(e);
                    m_pending = 1;
                    m_pend_ch = m_cur;
                end else if (m_over != 16'hFFFF) begin
                    m_over = m_over + 16'd1;
                end
                m_seq = m_seq + 16'd1;
                m_cur = (m_cur + 1) % NUM_CH;
            end
            m_count = enable ? (m_count + 1) % INTERVAL : 0;
        end
    end

    // Monitor: compares DUT outputs against the model away from the clock edge
    always @(negedge clock) begin
        logic [3:0] exp_head;
        if (m_valid) begin
            exp_head = {2'(m_head[1]), 2'(m_head[0])};
            check("wr_en", 32'(wr_bus.wr_en), 32'(m_pending));
            check("cur_ch", 32'(cur_ch), 32'(m_cur));
            check("head_idx", 32'(head_idx), 32'(exp_head));
            check("wrapped", 32'(wrapped), 32'(m_wrapped));
            check("overrun_cnt", 32'(overrun_cnt), 32'(m_over));
            if (wr_bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(wr_bus.wr_addr), 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", 32'(wr_bus.wr_addr), 32'(exp_q[0].addr));
                    check("wr_data", wr_bus.wr_data, exp_q[0].data);
                    if (wr_bus.wr_ready && !reset) begin
                        log_q.push_back(exp_t'({wr_bus.wr_addr, wr_bus.wr_data}));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] sample_word(input int idx, input logic [15:0] smp);
`ifdef SEQ_TIMESTAMP_EN
        return {16'(idx), smp};
`else
        return {16'h0, smp + 16'(idx * 0)};
`endif
    endfunction

    initial begin
        logic [11:0] ea;
        logic [15:0] es;
        int          seq_map [3];
        reset          = 1'b1;
        enable         = 1'b0;
        ch_data        = '0;
        wr_bus.wr_ready = 1'b0;

        // Free-running capture with the port always ready, through ring wrap
        do_reset();
        ch_data         = {16'h0456, 16'h0123};
        wr_bus.wr_ready = 1'b1;
        enable          = 1'b1;
        log_q.delete();
        cycles(38);
        check("s1_log_size", 32'(log_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < log_q.size(); i++) begin
            ea = ((i % 2) ? 12'hA80 : 12'h800) + 12'((i / 2) % 4);
            es = (i % 2) ? 16'h0456 : 16'h0123;
            check("s1_addr", 32'(log_q[i].addr), 32'(ea));
            check("s1_data", log_q[i].data, sample_word(i, es));
        end
        check("s1_wrapped", 32'(wrapped), 32'h3);
        check("s1_head_idx", 32'(head_idx), 32'h1);
        check("s1_overrun", 32'(overrun_cnt), 32'h0);

        // Stalled channel-0 request: the channel-1 tick is dropped
        do_reset();
        wr_bus.wr_ready = 1'b0;
        log_q.delete();
        cycles(10);
        wr_bus.wr_ready = 1'b1;
        cycles(8);
        seq_map = '{0, 2, 3};
        check("s4_overrun", 32'(overrun_cnt), 32'h1);
        check("s4_head_idx", 32'(head_idx), 32'h6);
        check("s4_cur_ch", 32'(cur_ch), 32'h0);
        check("s4_log_size", 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) begin
            ea = (i == 2) ? 12'hA80 : 12'h800 + 12'(i);
            es = (i == 2) ? 16'h0456 : 16'h0123;
            check("s4_addr", 32'(log_q[i].addr), 32'(ea));
            check("s4_data", log_q[i].data, sample_word(seq_map[i], es));
        end

        // Reset while a request is stalled
        wr_bus.wr_ready = 1'b0;
        cycles(3);
        check("s5_req_pending", 32'(wr_bus.wr_en), 32'h1);
        reset = 1'b1;
        cycles(1);
        check("s5_wr_en_low", 32'(wr_bus.wr_en), 32'h0);
        check("s5_head_zero", 32'(head_idx), 32'h0);
        check("s5_wrapped_zero", 32'(wrapped), 32'h0);
        check("s5_overrun_zero", 32'(overrun_cnt), 32'h0);
        reset           = 1'b0;
        wr_bus.wr_ready = 1'b1;
        log_q.delete();
        cycles(3);
        check("s5_no_write", 32'(log_q.size()), 32'd0);

        // Randomised traffic with alternating ready-rich and ready-starved phases
        for (int n = 0; n < 3000; n++) begin
            int rdy_pct;
            rdy_pct         = ((n / 60) % 2) ? 20 : 90;
            ch_data         = $urandom;
            wr_bus.wr_ready = ($urandom_range(99) < rdy_pct);
            enable          = ($urandom_range(99) < 95);
            reset           = ($urandom_range(999) < 3);
            cycles(1);
        end
        reset = 1'b0;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
